// File: rtl/id_branch_resolve.sv
// ID-stage branch resolve: PC, IF/ID and ID/EX control registers.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module id_branch_resolve #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              EX_Flush,
  input  logic [1:0]        ForwardA,
  input  logic [1:0]        ForwardB,
  input  logic [31:0]       IF_Inst,
  input  logic [31:0]       RegRs_Data,
  input  logic [31:0]       RegRt_Data,
  input  logic [31:0]       MEM_ALUOut,
  input  logic [31:0]       WB_WriteData,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  output logic [31:0]       PC,
  output logic [31:0]       ID_Inst,
  output logic [31:0]       ID_PCPlus4,
  output logic              BranchTaken,
  output logic [31:0]       BranchTarget,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic [31:0]       StallCount,
  output logic [31:0]       TakenCount
);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       pc4_q, pc4_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       op_a, op_b;
  logic [31:0]       pc_plus4;
  logic [31:0]       imm_sh;
  logic              is_beq, is_bne;
  logic              ops_eq;

  always_comb begin
    case (ForwardA)
      2'b10:   op_a = MEM_ALUOut;
      2'b01:   op_a = WB_WriteData;
      default: op_a = RegRs_Data;
    endcase
    case (ForwardB)
      2'b10:   op_b = MEM_ALUOut;
      2'b01:   op_b = WB_WriteData;
      default: op_b = RegRt_Data;
    endcase
  end

  assign is_beq   = (inst_q[31:26] == 6'b000100);
  assign is_bne   = (inst_q[31:26] == 6'b000101);
  assign ops_eq   = (op_a == op_b);
  assign pc_plus4 = pc_q + 32'd4;
  assign imm_sh   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  // Stalled operands are not valid yet, so PCWrite gates resolution.
  assign BranchTaken  = PCWrite &
                        ((is_beq & ops_eq) | (is_bne & ~ops_eq));
  assign BranchTarget = pc4_q + imm_sh;

  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    pc4_d  = pc4_q;
    ctrl_d = EX_Flush ? '0 : ID_Ctrl;
    if (PCWrite)
      pc_d = BranchTaken ? BranchTarget : pc_plus4;
    if (IF_ID_Write) begin
      if (BranchTaken) begin
        inst_d = '0;
        pc4_d  = '0;
      end else begin
        inst_d = IF_Inst;
        pc4_d  = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      inst_q <= '0;
      pc4_q  <= '0;
      ctrl_q <= '0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      pc4_q  <= pc4_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign PC         = pc_q;
  assign ID_Inst    = inst_q;
  assign ID_PCPlus4 = pc4_q;
  assign EX_Ctrl    = ctrl_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] taken_q, taken_d;

  always_comb begin
    stall_d = stall_q;
    taken_d = taken_q;
    if (!PCWrite && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
    if (BranchTaken && taken_q != 32'hFFFF_FFFF)
      taken_d = taken_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      taken_q <= '0;
    end else begin
      stall_q <= stall_d;
      taken_q <= taken_d;
    end
  end

  assign StallCount = stall_q;
  assign TakenCount = taken_q;
`else
  assign StallCount = 32'd0;
  assign TakenCount = 32'd0;
`endif

endmodule
